// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus the shared ALU connection.
// The arbiter takes the slave view; requesters and the ALU together form the master view.
interface alu_arbiter_if;
   logic        req0Valid;
   logic        req0Ready;
   logic [5:0]  req0OpCode;
   logic [31:0] req0Operand1;
   logic [31:0] req0Operand2;
   logic        resp0Valid;
   logic        resp0Ready;
   logic [31:0] resp0Result;
   logic        resp0Illegal;
   logic        req1Valid;
   logic        req1Ready;
   logic [5:0]  req1OpCode;
   logic [31:0] req1Operand1;
   logic [31:0] req1Operand2;
   logic        resp1Valid;
   logic        resp1Ready;
   logic [31:0] resp1Result;
   logic        resp1Illegal;
   logic [5:0]  aluOpCode;
   logic [31:0] aluOperand1;
   logic [31:0] aluOperand2;
   logic [31:0] aluResult;

   modport slave (
      input  req0Valid, req0OpCode, req0Operand1, req0Operand2, resp0Ready,
      input  req1Valid, req1OpCode, req1Operand1, req1Operand2, resp1Ready,
      input  aluResult,
      output req0Ready, resp0Valid, resp0Result, resp0Illegal,
      output req1Ready, resp1Valid, resp1Result, resp1Illegal,
      output aluOpCode, aluOperand1, aluOperand2
   );

   modport master (
      output req0Valid, req0OpCode, req0Operand1, req0Operand2, resp0Ready,
      output req1Valid, req1OpCode, req1Operand1, req1Operand2, resp1Ready,
      output aluResult,
      input  req0Ready, resp0Valid, resp0Result, resp0Illegal,
      input  req1Ready, resp1Valid, resp1Result, resp1Illegal,
      input  aluOpCode, aluOperand1, aluOperand2
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational 32-bit ALU: grant, hold the
// ALU inputs for EXEC_CYCLES cycles, capture the result and hold it until accepted.
module alu_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter bit          ROUND_ROBIN = 1'b1
) (
   input  logic         clk,
   input  logic         resetN,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   function automatic logic is_illegal(input logic [5:0] op);
      return (op > 6'd4);
   endfunction

   state_t      state_r, state_next_s;
   logic        ptr_r, gid_r, win_s, grant_s, resp_ack_s, illegal_s;
   logic [3:0]  cnt_r;
   logic [5:0]  op_r;
   logic [31:0] opa_r, opb_r, capture_s;
   logic        valid0_r, valid1_r, ill0_r, ill1_r;
   logic [31:0] result0_r, result1_r;

   assign resp_ack_s = gid_r ? bus.resp1Ready : bus.resp0Ready;
   assign illegal_s  = is_illegal(op_r);
   assign capture_s  = illegal_s ? 32'd0 : bus.aluResult;

   // Winner among the valid requesters; the pointer only matters on a tie
   always_comb begin
      win_s = 1'b0;
      if (bus.req0Valid && bus.req1Valid) begin
         win_s = ROUND_ROBIN ? ptr_r : 1'b0;
      end else if (bus.req1Valid) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Next-state and grant decode; ready is held low while reset is asserted
   always_comb begin
      state_next_s = state_r;
      grant_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (resetN && (bus.req0Valid || bus.req1Valid)) begin
               grant_s      = 1'b1;
               state_next_s = EXEC;
            end else begin
               state_next_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r == 4'd0) state_next_s = RESP;
            else               state_next_s = EXEC;
         end
         RESP: begin
            if (resp_ack_s) state_next_s = IDLE;
            else            state_next_s = RESP;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_r <= IDLE;
      else         state_r <= state_next_s;
   end

   // Operand latch, settle countdown, result capture and per-port response registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ptr_r     <= 1'b0;
         gid_r     <= 1'b0;
         cnt_r     <= 4'd0;
         op_r      <= 6'd0;
         opa_r     <= 32'd0;
         opb_r     <= 32'd0;
         valid0_r  <= 1'b0;
         valid1_r  <= 1'b0;
         ill0_r    <= 1'b0;
         ill1_r    <= 1'b0;
         result0_r <= 32'd0;
         result1_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  gid_r <= win_s;
                  cnt_r <= CNT_LOAD;
                  op_r  <= win_s ? bus.req1OpCode   : bus.req0OpCode;
                  opa_r <= win_s ? bus.req1Operand1 : bus.req0Operand1;
                  opb_r <= win_s ? bus.req1Operand2 : bus.req0Operand2;
                  ptr_r <= ROUND_ROBIN ? ~win_s : 1'b0;
               end
            end
            EXEC: begin
               if (cnt_r == 4'd0) begin
                  // ALU inputs return to ADD 0+0 once the result is taken
                  op_r  <= 6'd0;
                  opa_r <= 32'd0;
                  opb_r <= 32'd0;
                  if (gid_r) begin
                     valid1_r  <= 1'b1;
                     result1_r <= capture_s;
                     ill1_r    <= illegal_s;
                  end else begin
                     valid0_r  <= 1'b1;
                     result0_r <= capture_s;
                     ill0_r    <= illegal_s;
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (resp_ack_s) begin
                  valid0_r <= 1'b0;
                  valid1_r <= 1'b0;
               end
            end
            default: cnt_r <= 4'd0;
         endcase
      end
   end

   assign bus.req0Ready    = grant_s & ~win_s;
   assign bus.req1Ready    = grant_s & win_s;
   assign bus.resp0Valid   = valid0_r;
   assign bus.resp1Valid   = valid1_r;
   assign bus.resp0Result  = result0_r;
   assign bus.resp1Result  = result1_r;
   assign bus.resp0Illegal = ill0_r;
   assign bus.resp1Illegal = ill1_r;
   assign bus.aluOpCode    = op_r;
   assign bus.aluOperand1  = opa_r;
   assign bus.aluOperand2  = opb_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a round-robin instance with four settle cycles
// and a fixed-priority instance with one, both checked against a transaction-level model.
module tb_alu_arbiter;
   localparam int E = 4;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   ptr_m = 0;

   always #5 clk = ~clk;

   alu_arbiter_if bus();
   alu_arbiter_if bus_fp();

   alu_arbiter #(.EXEC_CYCLES(E), .ROUND_ROBIN(1'b1)) dut (
      .clk(clk), .resetN(resetN), .bus(bus.slave));
   alu_arbiter #(.EXEC_CYCLES(1), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .resetN(resetN), .bus(bus_fp.slave));

   // What the requester should receive: ALU arithmetic, or 0 for an illegal opcode
   function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'd0: return a + b;
         6'd1: return a - b;
         6'd2: return a & b;
         6'd3: return a | b;
         6'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // The ALU returns garbage on unknown opcodes so the arbiter's zeroing is visible
   function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      return (op > 6'd4) ? 32'hDEAD_BEEF : ref_result(op, a, b);
   endfunction

   assign bus.aluResult    = alu_f(bus.aluOpCode, bus.aluOperand1, bus.aluOperand2);
   assign bus_fp.aluResult = alu_f(bus_fp.aluOpCode, bus_fp.aluOperand1, bus_fp.aluOperand2);

   // One transaction on the main instance; called and returns in the low clock phase of an IDLE cycle
   task automatic serve(input bit v0, input bit v1,
                        input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int stall, input bit keep, output int w);
      logic [5:0]  op;
      logic [31:0] a, b, er, res;
      logic        ei, il;
      bus.req0Valid = v0; bus.req0OpCode = op0; bus.req0Operand1 = a0; bus.req0Operand2 = b0;
      bus.req1Valid = v1; bus.req1OpCode = op1; bus.req1Operand1 = a1; bus.req1Operand2 = b1;
      bus.resp0Ready = (stall == 0);
      bus.resp1Ready = (stall == 0);
      #1;
      w = (!v0 && !v1) ? -1 : ((v0 && v1) ? ptr_m : (v1 ? 1 : 0));
      total++;
      if ({bus.req0Ready, bus.req1Ready} !== {w == 0, w == 1})
         begin bad++; $display("FAIL grant: got ready=%b%b want winner %0d", bus.req0Ready, bus.req1Ready, w); end
      if (w < 0) begin
         @(negedge clk);
         return;
      end
      ptr_m = 1 - w;
      op = (w == 1) ? op1 : op0;
      a  = (w == 1) ? a1 : a0;
      b  = (w == 1) ? b1 : b0;
      er = ref_result(op, a, b);
      ei = (op > 6'd4);
      @(posedge clk); #1;
      if (!keep) begin
         bus.req0Valid = 1'b0;
         bus.req1Valid = 1'b0;
      end
      for (int i = 0; i < E; i++) begin
         @(negedge clk);
         total++;
         if ({bus.aluOpCode, bus.aluOperand1, bus.aluOperand2, bus.resp0Valid, bus.resp1Valid, bus.req0Ready, bus.req1Ready}
             !== {op, a, b, 4'b0000})
            begin bad++; $display("FAIL exec[%0d]: got alu=%h %h %h vld=%b%b rdy=%b%b want alu=%h %h %h all flags 0", i,
                   bus.aluOpCode, bus.aluOperand1, bus.aluOperand2, bus.resp0Valid, bus.resp1Valid,
                   bus.req0Ready, bus.req1Ready, op, a, b); end
      end
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         if (stall > 0) begin
            if (w == 1) bus.req0Valid = (s < stall);
            else        bus.req1Valid = (s < stall);
         end
         if (s == stall) begin
            bus.resp0Ready = 1'b1;
            bus.resp1Ready = 1'b1;
         end
         #1;
         res = (w == 1) ? bus.resp1Result : bus.resp0Result;
         il  = (w == 1) ? bus.resp1Illegal : bus.resp0Illegal;
         total++;
         if ({bus.resp0Valid, bus.resp1Valid, res, il, bus.req0Ready, bus.req1Ready, bus.aluOpCode, bus.aluOperand1, bus.aluOperand2}
             !== {w == 0, w == 1, er, ei, 2'b00, 6'd0, 32'd0, 32'd0})
            begin bad++; $display("FAIL resp[%0d]: got vld=%b%b res=%h ill=%b rdy=%b%b alu=%h want vld=%b%b res=%h ill=%b rdy=00 alu=0",
                   s, bus.resp0Valid, bus.resp1Valid, res, il, bus.req0Ready, bus.req1Ready, bus.aluOpCode,
                   w == 0, w == 1, er, ei); end
      end
      @(negedge clk);
      total++;
      if ({bus.resp0Valid, bus.resp1Valid} !== 2'b00)
         begin bad++; $display("FAIL release: got vld=%b%b want 00", bus.resp0Valid, bus.resp1Valid); end
   endtask

   task automatic test_reset();
      logic [139:0] v;
      bus.req0Valid = 1'b1; bus.req1Valid = 1'b1;
      @(negedge clk);
      v = {bus.req0Ready, bus.req1Ready, bus.resp0Valid, bus.resp1Valid, bus.resp0Illegal, bus.resp1Illegal,
           bus.resp0Result, bus.resp1Result, bus.aluOpCode, bus.aluOperand1, bus.aluOperand2};
      total++;
      if (v !== 140'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", v); end
      bus.req0Valid = 1'b0; bus.req1Valid = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int w;
      serve(1'b1, 1'b0, 6'd0, 32'd5, 32'd7, 6'd0, 32'd0, 32'd0, 0, 1'b0, w);
      serve(1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 6'd4, -32'sd3, 32'd2, 0, 1'b0, w);
      serve(1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 6'd1, 32'd2, 32'd5, 0, 1'b0, w);
      serve(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 6'd0, 32'd0, 32'd0, 0, 1'b0, w);
   endtask

   task automatic test_illegal();
      int w;
      serve(1'b1, 1'b0, 6'h3F, 32'd1, 32'd1, 6'd0, 32'd0, 32'd0, 0, 1'b0, w);
      serve(1'b1, 1'b0, 6'd3, 32'hF0, 32'h0F, 6'd0, 32'd0, 32'd0, 0, 1'b0, w);
   endtask

   task automatic test_back_to_back();
      logic [5:0]  po [2];
      logic [31:0] pa [2], pb [2];
      int w, prev;
      for (int p = 0; p < 2; p++) begin
         po[p] = 6'($urandom_range(0, 4)); pa[p] = $urandom; pb[p] = $urandom;
      end
      prev = -1;
      for (int g = 0; g < 4; g++) begin
         serve(1'b1, 1'b1, po[0], pa[0], pb[0], po[1], pa[1], pb[1], 0, 1'b1, w);
         total++;
         if (w == prev) begin bad++; $display("FAIL alternation[%0d]: got port %0d twice", g, w); end
         prev = w;
         po[w] = 6'($urandom_range(0, 4)); pa[w] = $urandom; pb[w] = $urandom;
      end
      bus.req0Valid = 1'b0; bus.req1Valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fixed_priority();
      bus_fp.req0Valid = 1'b1; bus_fp.req0OpCode = 6'd0; bus_fp.req0Operand1 = 32'd100; bus_fp.req0Operand2 = 32'd23;
      bus_fp.req1Valid = 1'b1; bus_fp.req1OpCode = 6'd1; bus_fp.req1Operand1 = 32'd9;   bus_fp.req1Operand2 = 32'd4;
      bus_fp.resp0Ready = 1'b1; bus_fp.resp1Ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         total++;
         if ({bus_fp.req0Ready, bus_fp.req1Ready, bus_fp.resp0Valid, bus_fp.resp1Valid} !== {c % 3 == 0, 1'b0, c % 3 == 2, 1'b0})
            begin bad++; $display("FAIL fixed_prio[%0d]: got rdy=%b%b vld=%b%b want rdy=%b0 vld=%b0", c, bus_fp.req0Ready,
                   bus_fp.req1Ready, bus_fp.resp0Valid, bus_fp.resp1Valid, c % 3 == 0, c % 3 == 2); end
         if (c % 3 == 2) begin
            total++;
            if (bus_fp.resp0Result !== 32'd123)
               begin bad++; $display("FAIL fixed_prio_result[%0d]: got %h want 0000007b", c, bus_fp.resp0Result); end
         end
         @(negedge clk);
      end
      bus_fp.req0Valid = 1'b0; bus_fp.req1Valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stall();
      int w;
      serve(1'b0, 1'b1, 6'd0, 32'd11, 32'd22, 6'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 10, 1'b0, w);
   endtask

   task automatic test_random();
      int w, r0, r1;
      logic [5:0] o0, o1;
      for (int n = 0; n < 20; n++) begin
         r0 = $urandom_range(0, 6); r1 = $urandom_range(0, 6);
         o0 = (r0 < 5) ? 6'(r0) : 6'($urandom_range(5, 63));
         o1 = (r1 < 5) ? 6'(r1) : 6'($urandom_range(5, 63));
         serve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o0, $urandom, $urandom, o1, $urandom, $urandom,
               $urandom_range(0, 2), 1'b0, w);
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [139:0] v;
      int w;
      serve(1'b1, 1'b0, 6'd0, 32'd3, 32'd4, 6'd0, 32'd0, 32'd0, 0, 1'b0, w);
      bus.req0Valid = 1'b1; bus.req0OpCode = 6'd1; bus.req0Operand1 = 32'd9; bus.req0Operand2 = 32'd4;
      @(posedge clk); #1;
      bus.req0Valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b0;
      ptr_m = 0;
      #1;
      v = {bus.req0Ready, bus.req1Ready, bus.resp0Valid, bus.resp1Valid, bus.resp0Illegal, bus.resp1Illegal,
           bus.resp0Result, bus.resp1Result, bus.aluOpCode, bus.aluOperand1, bus.aluOperand2};
      total++;
      if (v !== 140'd0) begin bad++; $display("FAIL mid_exec_reset: got %h want 0", v); end
      @(negedge clk);
      resetN = 1'b1;
      for (int c = 0; c < E + 3; c++) begin
         @(negedge clk);
         total++;
         if ({bus.resp0Valid, bus.resp1Valid, bus.aluOperand1} !== 34'd0)
            begin bad++; $display("FAIL dropped_txn[%0d]: got vld=%b%b alu_a=%h want 0", c, bus.resp0Valid,
                   bus.resp1Valid, bus.aluOperand1); end
      end
      serve(1'b1, 1'b1, 6'd0, 32'd10, 32'd20, 6'd1, 32'd1, 32'd1, 0, 1'b0, w);
      total++;
      if (w != 0) begin bad++; $display("FAIL ptr_after_reset: got port %0d want 0", w); end
   endtask

   initial begin
      bus.req0Valid = 1'b0; bus.req0OpCode = 6'd0; bus.req0Operand1 = 32'd0; bus.req0Operand2 = 32'd0;
      bus.req1Valid = 1'b0; bus.req1OpCode = 6'd0; bus.req1Operand1 = 32'd0; bus.req1Operand2 = 32'd0;
      bus.resp0Ready = 1'b0; bus.resp1Ready = 1'b0;
      bus_fp.req0Valid = 1'b0; bus_fp.req0OpCode = 6'd0; bus_fp.req0Operand1 = 32'd0; bus_fp.req0Operand2 = 32'd0;
      bus_fp.req1Valid = 1'b0; bus_fp.req1OpCode = 6'd0; bus_fp.req1Operand1 = 32'd0; bus_fp.req1Operand2 = 32'd0;
      bus_fp.resp0Ready = 1'b0; bus_fp.resp1Ready = 1'b0;
      test_reset();
      test_basic();
      test_illegal();
      test_back_to_back();
      test_fixed_priority();
      test_stall();
      test_random();
      test_reset_mid_exec();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
